// File: rtl/rca_bist_ctrl_if.sv
// Bus between the adder BIST controller and the cells/selector it exercises.
// slave = controller side, master = cell array / environment side.
interface rca_bist_ctrl_if;
  logic       start;
  logic [3:0] sum_obs;
  logic [3:0] cout_obs;
  logic [3:0] a_t;
  logic [3:0] b_t;
  logic [3:0] cin_t;
  logic       test;
  logic [7:0] comp;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fault_mask;
  logic       multi_fault;
  logic [3:0] err_count;

  modport slave (
    input  start, sum_obs, cout_obs,
    output a_t, b_t, cin_t, test, comp, busy, done, pass,
           fault_mask, multi_fault, err_count
  );

  modport master (
    output start, sum_obs, cout_obs,
    input  a_t, b_t, cin_t, test, comp, busy, done, pass,
           fault_mask, multi_fault, err_count
  );
endinterface

// File: rtl/rca_bist_ctrl.sv
// Exhaustive 8-vector self-test of four full-adder cells: broadcasts each vector,
// compares cell outputs to golden sum/carry and accumulates per-cell fault flags.
module rca_bist_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic           clk,
  input  logic           init,
  rca_bist_ctrl_if.slave bus
);

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, FLUSH, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] v_q, v_d;
  logic [3:0] cnt_q, cnt_d;
  logic       run_start;

  logic       test_q, a_q, b_q, c_q;
  logic [7:0] comp_q;
  logic       done_q, pass_q, multi_q;
  logic [3:0] fm_q, ec_q;

  logic       gs, gc;
  logic [7:0] comp_c;
  logic       test_d, vec_on_d;

  // Golden full-adder response for the current vector
  assign gs     = v_q[2] ^ v_q[1] ^ v_q[0];
  assign gc     = (v_q[2] & v_q[1]) | (v_q[2] & v_q[0]) | (v_q[1] & v_q[0]);
  assign comp_c = {bus.cout_obs ^ {4{gc}}, bus.sum_obs ^ {4{gs}}};

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    cnt_d     = cnt_q;
    run_start = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = APPLY;
          v_d       = 3'd0;
          run_start = 1'b1;
        end
      end
      APPLY: begin
        cnt_d   = SETTLE_W - 4'd1;
        state_d = (SETTLE_W == 4'd0) ? CHECK : WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CHECK: begin
        if (v_q == 3'd7) begin
          state_d = FLUSH;
        end else begin
          state_d = APPLY;
          v_d     = v_q + 3'd1;
        end
      end
      FLUSH:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Registered state-decoded outputs are computed from the next state
  assign test_d   = (state_d == APPLY) || (state_d == WAIT) ||
                    (state_d == CHECK) || (state_d == FLUSH);
  assign vec_on_d = (state_d == APPLY) || (state_d == WAIT) || (state_d == CHECK);

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q <= IDLE;
      v_q     <= 3'd0;
      cnt_q   <= 4'd0;
      test_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      comp_q  <= 8'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      multi_q <= 1'b0;
      fm_q    <= 4'd0;
      ec_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      test_q  <= test_d;
      a_q     <= vec_on_d & v_d[2];
      b_q     <= vec_on_d & v_d[1];
      c_q     <= vec_on_d & v_d[0];
      comp_q  <= (state_q == CHECK) ? comp_c : 8'd0;
      if (run_start) begin
        fm_q    <= 4'd0;
        ec_q    <= 4'd0;
        done_q  <= 1'b0;
        pass_q  <= 1'b0;
        multi_q <= 1'b0;
      end else if (state_q == CHECK) begin
        fm_q <= fm_q | comp_c[3:0] | comp_c[7:4];
        if ((comp_c != 8'd0) && (ec_q != 4'd15)) ec_q <= ec_q + 4'd1;
      end else if (state_q == FLUSH) begin
        done_q  <= 1'b1;
        pass_q  <= (fm_q == 4'd0);
        // more than one bit set <=> clearing the lowest set bit leaves something
        multi_q <= ((fm_q & (fm_q - 4'd1)) != 4'd0);
      end
    end
  end

  assign bus.a_t         = {4{a_q}};
  assign bus.b_t         = {4{b_q}};
  assign bus.cin_t       = {4{c_q}};
  assign bus.test        = test_q;
  assign bus.busy        = test_q;
  assign bus.comp        = comp_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fault_mask  = fm_q;
  assign bus.multi_fault = multi_q;
  assign bus.err_count   = ec_q;

endmodule

// File: tb/tb_rca_bist_ctrl.sv
// Directed bench for rca_bist_ctrl: SETTLE=1 and SETTLE=0 instances driving
// a behavioural four-cell full-adder array with injectable stuck-at faults.
module tb_rca_bist_ctrl;

  logic clk   = 1'b0;
  bit   clk_en = 1'b0;
  logic init  = 1'b0;
  logic start = 1'b0;
  bit   dsel  = 1'b1;

  logic [3:0] sa0s = '0, sa1s = '0, sa0c = '0, sa1c = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  rca_bist_ctrl_if if1();
  rca_bist_ctrl_if if0();

  rca_bist_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .init(init), .bus(if1.slave));
  rca_bist_ctrl #(.SETTLE(0)) u_dut0 (.clk(clk), .init(init), .bus(if0.slave));

  // Full-adder cell array with stuck-at overrides; returns {cout, sum}
  function automatic logic [7:0] cells(input logic [3:0] a, b, c,
                                       input logic [3:0] s0s, s1s, s0c, s1c);
    logic [3:0] s, co;
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    s  = (s & ~s0s) | s1s;
    co = (co & ~s0c) | s1c;
    return {co, s};
  endfunction

  assign if1.start = start & dsel;
  assign if0.start = start & ~dsel;
  assign {if1.cout_obs, if1.sum_obs} = cells(if1.a_t, if1.b_t, if1.cin_t, sa0s, sa1s, sa0c, sa1c);
  assign {if0.cout_obs, if0.sum_obs} = cells(if0.a_t, if0.b_t, if0.cin_t, sa0s, sa1s, sa0c, sa1c);

  logic [32:0] outs1, outs0;
  assign outs1 = {if1.test, if1.busy, if1.done, if1.pass, if1.multi_fault, if1.comp,
                  if1.fault_mask, if1.err_count, if1.a_t, if1.b_t, if1.cin_t};
  assign outs0 = {if0.test, if0.busy, if0.done, if0.pass, if0.multi_fault, if0.comp,
                  if0.fault_mask, if0.err_count, if0.a_t, if0.b_t, if0.cin_t};

  logic        test_s, busy_s, done_s, pass_s, multi_s;
  logic [7:0]  comp_s;
  logic [3:0]  fm_s, ec_s;
  logic [11:0] vec_s;
  assign {test_s, busy_s, done_s, pass_s, multi_s, comp_s, fm_s, ec_s, vec_s} = dsel ? outs1 : outs0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One start pulse, then walk the run comparing comp per vector and the end status
  task automatic run_check(input int settle, input logic [63:0] exp_comp,
                           input logic [3:0] exp_fm, input logic [3:0] exp_ec,
                           input logic exp_pass, input logic exp_multi, input bit spam);
    int period, n, bad, k;
    logic [2:0]  kv;
    logic [11:0] vexp;
    period = settle + 2;
    n = 0;
    bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!spam) start = 1'b0;
    while (test_s === 1'b1 && n < 200) begin
      if (n == 0) check("sticky_clr", {done_s, pass_s, multi_s, fm_s, ec_s}, 64'd0);
      if (n > 0 && n % period == 0) begin
        k = n / period - 1;
        check($sformatf("comp_v%0d", k), comp_s, exp_comp[k*8 +: 8]);
      end else if (comp_s !== 8'd0) begin
        bad++;
      end
      if (n < 8 * period) begin
        kv   = 3'(n / period);
        vexp = {{4{kv[2]}}, {4{kv[1]}}, {4{kv[0]}}};
      end else begin
        vexp = 12'd0;
      end
      if (vec_s !== vexp) bad++;
      if (busy_s !== test_s) bad++;
      n++;
      if (spam) start = ~start;
      @(negedge clk);
    end
    start = 1'b0;
    check("test_len", 64'(n), 64'(8 * period + 1));
    check("shape_errs", 64'(bad), 64'd0);
    check("done", done_s, 1'b1);
    check("pass", pass_s, exp_pass);
    check("fault_mask", fm_s, exp_fm);
    check("err_count", ec_s, exp_ec);
    check("multi_fault", multi_s, exp_multi);
    check("done_quiet", {busy_s, comp_s, vec_s}, 64'd0);
  endtask

  initial begin
    int hi_cnt, done_cnt;
    // Reset with the clock stopped
    #1 init = 1'b1;
    #2;
    check("rst_outs_s1", outs1, 64'd0);
    check("rst_outs_s0", outs0, 64'd0);
    #5 init = 1'b0;
    clk_en = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_outs_s1", outs1, 64'd0);
    check("idle_outs_s0", outs0, 64'd0);

    dsel = 1'b1;
    run_check(1, 64'h0, 4'b0000, 4'd0, 1'b1, 1'b0, 1'b0);

    sa0s = 4'b0100;
    run_check(1, 64'h04_00_00_04_00_04_04_00, 4'b0100, 4'd4, 1'b0, 1'b0, 1'b0);

    sa0s = 4'b0000;
    sa1c = 4'b0001;
    sa1s = 4'b1000;
    run_check(1, 64'h00_08_08_10_08_10_10_18, 4'b1001, 4'd7, 1'b0, 1'b1, 1'b0);
    run_check(1, 64'h00_08_08_10_08_10_10_18, 4'b1001, 4'd7, 1'b0, 1'b1, 1'b1);

    sa1c = 4'b0000;
    sa1s = 4'b0000;
    dsel = 1'b0;
    run_check(0, 64'h0, 4'b0000, 4'd0, 1'b1, 1'b0, 1'b0);

    // Abort a SETTLE=0 run mid-way with init
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_busy", test_s, 1'b1);
    #2 init = 1'b1;
    #1 check("abort_outs", outs0, 64'd0);
    @(negedge clk);
    init = 1'b0;
    hi_cnt = 0;
    done_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (test_s === 1'b1) hi_cnt++;
      if (done_s === 1'b1) done_cnt++;
    end
    check("abort_no_run", 64'(hi_cnt), 64'd0);
    check("abort_no_done", 64'(done_cnt), 64'd0);

    sa0s = 4'b0100;
    run_check(0, 64'h04_00_00_04_00_04_04_00, 4'b0100, 4'd4, 1'b0, 1'b0, 1'b0);
    sa0s = 4'b0000;
    run_check(0, 64'h0, 4'b0000, 4'd0, 1'b1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
